cdb_broadcast_arbiter: RTL and testbench

//  Producer side of the common data bus (CDB). Collects completed results from NSRC functional

---
 rtl/cdb_broadcast_arbiter_pkg.sv | 14 +
 rtl/cdb_src_fifo.sv | 47 ++++
 rtl/cdb_broadcast_arbiter.sv | 97 +++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cdb_broadcast_arbiter_pkg.sv
// cdb_broadcast_arbiter_pkg: common data bus field widths and the entry layout
// shared by the arbiter and the bus snoopers.
package cdb_broadcast_arbiter_pkg;
  localparam int TAG_W = 5;
  localparam int DEST_W = 5;
  localparam int DATA_W = 32;
  localparam int CDB_ENTRY_W = TAG_W + DEST_W + DATA_W + 1;
  typedef struct packed {
    logic              wr;
    logic [TAG_W-1:0]  tag;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-producer result buffer; flush empties it and drops that cycle's push.
module cdb_src_fifo
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  cdb_entry_t mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign dout = mem_q[head_q];
  // Full blocks the push even when the head leaves this cycle: no bypass.
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  always_comb begin
    head_d = flush ? '0 : head_q + AW'(do_pop);
    tail_d = flush ? '0 : tail_q + AW'(do_push);
    count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din;
  end
endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// cdb_broadcast_arbiter: buffers results from NSRC producers and broadcasts up to two
// per cycle on two registered CDB lanes, granting round-robin.
module cdb_broadcast_arbiter
  import cdb_broadcast_arbiter_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NSRC-1:0]     src_valid,
  input  logic [NSRC-1:0]     src_wr,
  input  logic [5*NSRC-1:0]   src_tag,
  input  logic [5*NSRC-1:0]   src_dest,
  input  logic [32*NSRC-1:0]  src_data,
  output logic [NSRC-1:0]     src_ready,
  output logic                cdb1_valid,
  output logic                cdb1_wr,
  output logic [4:0]          cdb1_tag,
  output logic [4:0]          cdb1_dest,
  output logic [31:0]         cdb1_data,
  output logic                cdb2_valid,
  output logic                cdb2_wr,
  output logic [4:0]          cdb2_tag,
  output logic [4:0]          cdb2_dest,
  output logic [31:0]         cdb2_data
);
  localparam int RW = NSRC > 1 ? $clog2(NSRC) : 1;
  cdb_entry_t head [NSRC];
  cdb_entry_t l1_q, l1_d, l2_q, l2_d;
  logic [NSRC-1:0] empty, full, pop;
  logic [RW-1:0] rr_q, rr_d, g1, g2, last;
  logic g1_v, g2_v, v1_q, v1_d, v2_q, v2_d;
  int idx;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .flush(flush), .push(src_valid[i]), .pop(pop[i]),
      .din({src_wr[i], src_tag[5*i+:5], src_dest[5*i+:5], src_data[32*i+:32]}),
      .dout(head[i]), .empty(empty[i]), .full(full[i])
    );
  end
  assign src_ready = ~full;
  // Scan from rr: the first non-empty source takes lane1, the next takes lane2.
  always_comb begin
    g1 = '0;
    g2 = '0;
    g1_v = 1'b0;
    g2_v = 1'b0;
    idx = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!empty[idx] && !g1_v) begin
        g1 = RW'(idx);
        g1_v = 1'b1;
      end else if (!empty[idx] && !g2_v) begin
        g2 = RW'(idx);
        g2_v = 1'b1;
      end
    end
    pop = '0;
    if (g1_v) pop[g1] = 1'b1;
    if (g2_v) pop[g2] = 1'b1;
    last = g2_v ? g2 : g1;
    rr_d = flush ? '0 : !g1_v ? rr_q : last == RW'(NSRC-1) ? '0 : last + RW'(1);
    v1_d = g1_v & ~flush;
    v2_d = g2_v & ~flush;
    l1_d = v1_d ? head[g1] : {1'b0, l1_q.tag, l1_q.dest, l1_q.data};
    l2_d = v2_d ? head[g2] : {1'b0, l2_q.tag, l2_q.dest, l2_q.data};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= '0;
      l2_q <= '0;
    end else begin
      rr_q <= rr_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
    end
  end
  assign cdb1_valid = v1_q;
  assign cdb1_wr = l1_q.wr;
  assign cdb1_tag = l1_q.tag;
  assign cdb1_dest = l1_q.dest;
  assign cdb1_data = l1_q.data;
  assign cdb2_valid = v2_q;
  assign cdb2_wr = l2_q.wr;
  assign cdb2_tag = l2_q.tag;
  assign cdb2_dest = l2_q.dest;
  assign cdb2_data = l2_q.data;
endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb_cdb_broadcast_arbiter: scoreboard bench; a queue-based model predicts each lane's
// broadcasts and a monitor compares them as the lanes present valid results.
module tb_cdb_broadcast_arbiter;
  import cdb_broadcast_arbiter_pkg::*;
  localparam int NSRC = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst, flush;
  logic [NSRC-1:0] src_valid, src_wr, src_ready;
  logic [5*NSRC-1:0] src_tag, src_dest;
  logic [32*NSRC-1:0] src_data;
  logic cdb1_valid, cdb1_wr, cdb2_valid, cdb2_wr;
  logic [4:0] cdb1_tag, cdb1_dest, cdb2_tag, cdb2_dest;
  logic [31:0] cdb1_data, cdb2_data;
  int n_chk = 0, n_fail = 0;
  cdb_entry_t mq [NSRC][$];
  cdb_entry_t exp1 [$], exp2 [$];
  cdb_entry_t last1, last2;
  int rr_m;
  logic [4:0] tag_ctr;

  cdb_broadcast_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .src_valid(src_valid), .src_wr(src_wr),
    .src_tag(src_tag), .src_dest(src_dest), .src_data(src_data), .src_ready(src_ready),
    .cdb1_valid(cdb1_valid), .cdb1_wr(cdb1_wr), .cdb1_tag(cdb1_tag), .cdb1_dest(cdb1_dest),
    .cdb1_data(cdb1_data), .cdb2_valid(cdb2_valid), .cdb2_wr(cdb2_wr), .cdb2_tag(cdb2_tag),
    .cdb2_dest(cdb2_dest), .cdb2_data(cdb2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [CDB_ENTRY_W-1:0] got, input logic [CDB_ENTRY_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: pops the predicted entry whenever a lane presents a valid result.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cdb1_valid) begin
        if (exp1.size() == 0) chk("lane1_unexpected", {cdb1_wr, cdb1_tag, cdb1_dest, cdb1_data}, '0);
        else begin
          last1 = exp1.pop_front();
          chk("lane1", {cdb1_wr, cdb1_tag, cdb1_dest, cdb1_data}, last1);
        end
      end else chk("lane1_idle", {cdb1_wr, cdb1_tag, cdb1_dest, cdb1_data}, {1'b0, last1.tag, last1.dest, last1.data});
      if (cdb2_valid) begin
        if (exp2.size() == 0) chk("lane2_unexpected", {cdb2_wr, cdb2_tag, cdb2_dest, cdb2_data}, '0);
        else begin
          last2 = exp2.pop_front();
          chk("lane2", {cdb2_wr, cdb2_tag, cdb2_dest, cdb2_data}, last2);
        end
      end else chk("lane2_idle", {cdb2_wr, cdb2_tag, cdb2_dest, cdb2_data}, {1'b0, last2.tag, last2.dest, last2.data});
    end
  end

  // One clock of stimulus; the model predicts what the next edge broadcasts.
  task automatic step(input logic [NSRC-1:0] v, input logic [NSRC-1:0] w, input logic fl);
    cdb_entry_t e [NSRC];
    logic [NSRC-1:0] rdy;
    int g [$];
    @(negedge clk);
    #1;
    for (int i = 0; i < NSRC; i++) rdy[i] = mq[i].size() != DEPTH;
    chk("src_ready", CDB_ENTRY_W'(src_ready), CDB_ENTRY_W'(rdy));
    for (int i = 0; i < NSRC; i++) begin
      e[i] = '{wr: w[i], tag: tag_ctr, dest: 5'($urandom), data: $urandom};
      if (v[i]) tag_ctr = tag_ctr + 5'd1;
      src_wr[i] = e[i].wr;
      src_tag[5*i+:5] = e[i].tag;
      src_dest[5*i+:5] = e[i].dest;
      src_data[32*i+:32] = e[i].data;
    end
    src_valid = v;
    flush = fl;
    if (fl) begin
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      for (int k = 0; k < NSRC; k++)
        if (mq[(rr_m + k) % NSRC].size() > 0 && g.size() < 2) g.push_back((rr_m + k) % NSRC);
      if (g.size() > 0) begin
        exp1.push_back(mq[g[0]].pop_front());
        if (g.size() > 1) exp2.push_back(mq[g[1]].pop_front());
        rr_m = (g[g.size()-1] + 1) % NSRC;
      end
      for (int i = 0; i < NSRC; i++) if (v[i] && rdy[i]) mq[i].push_back(e[i]);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_valid"}, CDB_ENTRY_W'({cdb1_valid, cdb2_valid}), '0);
    chk({nm, "_lane1"}, {cdb1_wr, cdb1_tag, cdb1_dest, cdb1_data}, '0);
    chk({nm, "_lane2"}, {cdb2_wr, cdb2_tag, cdb2_dest, cdb2_data}, '0);
    chk({nm, "_ready"}, CDB_ENTRY_W'(src_ready), CDB_ENTRY_W'(4'b1111));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    src_valid = '0;
    flush = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    exp1.delete();
    exp2.delete();
    rr_m = 0;
    last1 = '0;
    last2 = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    src_valid = '0;
    src_wr = '0;
    src_tag = '0;
    src_dest = '0;
    src_data = '0;
    tag_ctr = '0;
    rr_m = 0;
    last1 = '0;
    last2 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b1;
    tag_ctr = 5'd5;
    step(4'b0100, 4'b0100, 1'b0);
    repeat (3) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    tag_ctr = 5'd1;
    step(4'b1111, 4'b1111, 1'b0);
    repeat (3) step('0, '0, 1'b0);
    repeat (20) step(4'b1111, 4'($urandom), 1'b0);
    repeat (6) step('0, '0, 1'b0);
    repeat (3) step(4'b1111, 4'($urandom), 1'b0);
    step(4'b1111, 4'($urandom), 1'b1);
    repeat (4) step('0, '0, 1'b0);
    repeat (200) step(4'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);
    repeat (10) step(4'b1111, 4'($urandom), 1'b0);
    async_reset();
    repeat (100) step(4'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);
    repeat (8) step('0, '0, 1'b0);
    @(negedge clk);
    #1;
    chk("lane1_drained", CDB_ENTRY_W'(exp1.size()), '0);
    chk("lane2_drained", CDB_ENTRY_W'(exp2.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
